manchester_tx_scheduler: RTL and testbench
==========================================

Name: manchester_tx_scheduler

Overview:
Packet-level round-robin scheduler that shares one manchester escape encoder between NUM_SRC AXI-Stream packet sources.
- Grants one source per packet.
- Prepends a one-beat channel header.
- Enforces a maximum payload length by truncating and draining.
- Inserts a minimum idle gap between packets.
- Its m_axis output feeds the escape encoder's s_axis input directly.

Parameters:
- NUM_SRC, 4: number of requesting sources (2..16).
- DATA_WIDTH, 8: beat width in bits.
- HDR_TAG, 8'hA0: header base value; header = HDR_TAG | grant_id, with grant_id in the low IDW bits (IDW = clog2(NUM_SRC)).
- MAX_LEN, 256: maximum payload beats per packet (>=1).
- IFG_CYCLES, 4: minimum idle cycles on m_axis between packets (0 allowed).

Ports:
- aclk  in  1  clock
- aresetn  in  1  synchronous, active-low reset
- enable  in  1  permits new grants; sampled only in IDLE
- s_axis_tdata  in  NUM_SRC*DATA_WIDTH  source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- s_axis_tvalid  in  NUM_SRC  per-source valid
- s_axis_tready  out  NUM_SRC  per-source ready
- s_axis_tlast  in  NUM_SRC  per-source last
- m_axis_tdata  out  DATA_WIDTH  registered output data
- m_axis_tvalid  out  1  registered output valid
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  registered output last
- grant_id  out  IDW  index of the current or most recent grantee
- busy  out  1  high whenever state != IDLE
- trunc_pulse  out  1  one-cycle pulse when a packet is truncated

Behaviour:
Reset (aresetn=0 at a clock edge):
- state=IDLE; m_axis_tvalid=0, tlast=0, tdata=0.
- s_axis_tready=0; trunc_pulse=0; busy=0.
- grant_id=NUM_SRC-1, so src0 wins first.
- Payload and gap counters = 0.
- Reset mid-packet abandons the packet; no tlast is emitted.

Output register:
- load_ok = !m_axis_tvalid || m_axis_tready.
- m_axis_tvalid/tdata/tlast change only on load_ok.
- Held values are stable while tvalid && !tready (AXI rule).

Round-robin:
- Search starts at grant_id+1 mod NUM_SRC and wraps.
- The first asserted s_axis_tvalid wins.
- Grant is locked until the packet completes; no preemption.

FSM states and transitions:
- IDLE: if enable and any tvalid, latch grant_id and load the header beat (tvalid=1, tlast=0), then go to HEADER. s_axis_tready = 0.
- HEADER: on m_axis_tready, clear tvalid and go to PAYLOAD. This gives exactly one bubble after the header. s_axis_tready = 0.
- PAYLOAD:
  - s_axis_tready[grant_id] = load_ok; all other readies are 0.
  - On an accepted beat: copy data, count++.
  - m_axis_tlast = s_tlast || (count == MAX_LEN-1).
  - If s_tlast, go to GAP.
  - Else if count reached MAX_LEN, pulse trunc_pulse and go to DRAIN.
- DRAIN:
  - s_axis_tready[grant_id] = 1; beats are discarded with no output.
  - On accepted tlast, go to GAP.
  - If the MAX_LEN-th beat itself carries tlast, there is no truncation and no DRAIN.
- GAP:
  - The gap counter increments only on cycles with m_axis_tvalid=0, i.e. after the final beat has been taken.
  - When count == IFG_CYCLES, go to IDLE.
  - With IFG_CYCLES=0, go to IDLE on the first cycle with tvalid=0.
- No combinational path from any s_axis input to m_axis_tvalid.

Boundary conditions:
- Payload counter width is clog2(MAX_LEN+1); it clears on every grant.
- Deasserting enable does not abort an in-flight packet; it only blocks new grants from IDLE.
- A source deasserting tvalid mid-packet stalls the scheduler in PAYLOAD; grant is held.
- grant_id holds its value through IDLE.

Decomposition:
- Package manchester_tx_pkg holds:
  - state encoding (IDLE=0, HEADER=1, PAYLOAD=2, DRAIN=3, GAP=4; 3 bits)
  - default HDR_TAG
  - an IDW helper function
- One sub-module, manchester_rr_arbiter: combinational round-robin pick.
  - Inputs: req[NUM_SRC], last_grant[IDW].
  - Outputs: gnt_valid, gnt_id[IDW].
  - Instantiated once; the FSM latches its result in IDLE.

Test Plan:
1. src0 sends packet 11,22,33 with m_tready=1 → output A0,11,22,33 with tlast on 33; one bubble after A0; busy high throughout.
2. src0 and src2 both continuously valid with 2-beat packets → headers in order A0,A2,A0,A2; the other source's tready stays 0 during each packet.
3. Single 8-beat packet with random m_tready (50%) → output sequence intact; tdata/tvalid/tlast stable while stalled.
4. MAX_LEN=4, src1 sends 6 beats 01..06 → output A1,01,02,03,04 with tlast on 04; trunc_pulse for 1 cycle; beats 05,06 accepted and discarded; next packet is served normally.
5. IFG_CYCLES=4, back-to-back packets from src3 → at least 4 cycles with m_tvalid=0 between the tlast handshake and the next A3 header; repeat with IFG_CYCLES=0 and expect a gap of exactly 1 cycle.
6. Reset asserted during PAYLOAD, then src1 requests → m_tvalid=0 and all tready=0 the cycle after reset; next grant goes to src0 if valid, else src1, each with a header.

Source files
------------

// File: rtl/manchester_tx_pkg.sv
// Shared types and constants for the manchester TX packet scheduler.
package manchester_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HEADER  = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_GAP     = 3'd4
  } state_e;

  localparam logic [7:0] HDR_TAG_DEFAULT = 8'hA0;

  // Width of a source index; a lone source still gets a 1-bit id.
  function automatic int idw(input int num_src);
    return (num_src <= 1) ? 1 : $clog2(num_src);
  endfunction

endpackage

// File: rtl/manchester_rr_arbiter.sv
// Combinational round-robin pick: first requester after last_grant_i, wrapping.
module manchester_rr_arbiter
  import manchester_tx_pkg::*;
#(
  parameter  int NUM_SRC = 4,
  localparam int IDW     = idw(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [IDW-1:0]     last_grant_i,
  output logic               gnt_valid_o,
  output logic [IDW-1:0]     gnt_id_o
);

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    int idx;
    gnt_valid_o = 1'b0;
    gnt_id_o    = last_grant_i;
    idx         = 0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = (int'(last_grant_i) + k) % NUM_SRC;
      if (!gnt_valid_o && req_i[idx]) begin
        gnt_valid_o = 1'b1;
        gnt_id_o    = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/manchester_tx_scheduler.sv
// Packet-level round-robin scheduler feeding one manchester escape encoder:
// header beat, length-limited payload with drain on truncation, idle gap between packets.
module manchester_tx_scheduler
  import manchester_tx_pkg::*;
#(
  parameter  int                    NUM_SRC    = 4,
  parameter  int                    DATA_WIDTH = 8,
  parameter  logic [DATA_WIDTH-1:0] HDR_TAG    = DATA_WIDTH'(HDR_TAG_DEFAULT),
  parameter  int                    MAX_LEN    = 256,
  parameter  int                    IFG_CYCLES = 4,
  localparam int                    IDW        = idw(NUM_SRC)
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic                          enable,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]            s_axis_tvalid,
  output logic [NUM_SRC-1:0]            s_axis_tready,
  input  logic [NUM_SRC-1:0]            s_axis_tlast,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [IDW-1:0]                grant_id,
  output logic                          busy,
  output logic                          trunc_pulse
);

  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int GW = (IFG_CYCLES > 0) ? $clog2(IFG_CYCLES + 1) : 1;

  state_e                state_q, state_d;
  logic [IDW-1:0]        grant_q, grant_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic                  trunc_q, trunc_d;

  logic                  load_ok;
  logic                  gnt_valid;
  logic [IDW-1:0]        gnt_id;
  logic [DATA_WIDTH-1:0] src_data;
  logic                  src_valid;
  logic                  src_last;
  logic                  at_limit;

  manchester_rr_arbiter #(.NUM_SRC(NUM_SRC)) u_arb (
    .req_i        (s_axis_tvalid),
    .last_grant_i (grant_q),
    .gnt_valid_o  (gnt_valid),
    .gnt_id_o     (gnt_id)
  );

  assign load_ok   = !valid_q || m_axis_tready;
  assign src_data  = s_axis_tdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
  assign src_valid = s_axis_tvalid[grant_q];
  assign src_last  = s_axis_tlast[grant_q];
  assign at_limit  = (cnt_q == CW'(MAX_LEN - 1));

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    data_d        = data_q;
    valid_d       = valid_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    gap_d         = gap_q;
    trunc_d       = 1'b0;
    s_axis_tready = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (enable && gnt_valid) begin
          grant_d = gnt_id;
          data_d  = HDR_TAG | DATA_WIDTH'(gnt_id);
          valid_d = 1'b1;
          last_d  = 1'b0;
          cnt_d   = '0;
          gap_d   = '0;
          state_d = ST_HEADER;
        end
      end

      // The header leaves with no payload behind it, giving one bubble.
      ST_HEADER: begin
        if (m_axis_tready) begin
          valid_d = 1'b0;
          state_d = ST_PAYLOAD;
        end
      end

      ST_PAYLOAD: begin
        s_axis_tready[grant_q] = load_ok;
        if (load_ok) begin
          if (src_valid) begin
            data_d  = src_data;
            valid_d = 1'b1;
            last_d  = src_last || at_limit;
            cnt_d   = cnt_q + CW'(1);
            if (src_last) begin
              state_d = ST_GAP;
            end else if (at_limit) begin
              trunc_d = 1'b1;
              state_d = ST_DRAIN;
            end
          end else begin
            valid_d = 1'b0;
          end
        end
      end

      // Remaining beats of an over-length packet are swallowed.
      ST_DRAIN: begin
        s_axis_tready[grant_q] = 1'b1;
        if (load_ok) valid_d = 1'b0;
        if (src_valid && src_last) state_d = ST_GAP;
      end

      // Gap counting starts on the edge the final beat leaves the register.
      ST_GAP: begin
        if (load_ok) begin
          valid_d = 1'b0;
          if (gap_q == GW'(IFG_CYCLES)) state_d = ST_IDLE;
          else                          gap_d   = gap_q + GW'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop updates from the same pre-edge values.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      grant_q <= IDW'(NUM_SRC - 1);
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      gap_q   <= '0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      trunc_q <= trunc_d;
    end
  end

  assign m_axis_tdata  = data_q;
  assign m_axis_tvalid = valid_q;
  assign m_axis_tlast  = last_q;
  assign grant_id      = grant_q;
  assign busy          = (state_q != ST_IDLE);
  assign trunc_pulse   = trunc_q;

endmodule

// File: tb/tb_manchester_tx_scheduler.sv
// Bench for manchester_tx_scheduler: two instances (long packets / IFG 4, MAX_LEN 4 / IFG 0)
// checked beat-by-beat against an expected packet stream built from header/length rules.
module tb_manchester_tx_scheduler;

  localparam int NS = 4;
  localparam int DW = 8;

  typedef struct packed {logic [7:0] data; logic last;} beat_t;
  typedef struct packed {logic [7:0] data; logic last; logic hdr; logic [1:0] src;} exp_t;
  typedef beat_t bq_t[$];
  typedef exp_t  eq_t[$];

  logic aclk = 1'b0;
  logic aresetn;
  logic enable;

  logic [NS*DW-1:0] s_tdata  [2];
  logic [NS-1:0]    s_tvalid [2];
  logic [NS-1:0]    s_tlast  [2];
  logic [NS-1:0]    s_tready [2];
  logic [DW-1:0]    m_tdata  [2];
  logic             m_tvalid [2];
  logic             m_tready [2];
  logic             m_tlast  [2];
  logic [1:0]       gid      [2];
  logic             busy     [2];
  logic             trunc    [2];

  bq_t  srcq   [2][NS];
  eq_t  expq   [2];
  eq_t  outlog [2];
  logic rmode  [2];

  int nvec = 0;
  int nerr = 0;
  int trunc_cnt   [2];
  int last_gap    [2];
  int last_bubble [2];

  always #5 aclk = ~aclk;

  manchester_tx_scheduler #(
    .NUM_SRC(NS), .DATA_WIDTH(DW), .HDR_TAG(8'hA0), .MAX_LEN(256), .IFG_CYCLES(4)
  ) dut0 (
    .aclk(aclk), .aresetn(aresetn), .enable(enable),
    .s_axis_tdata(s_tdata[0]), .s_axis_tvalid(s_tvalid[0]), .s_axis_tready(s_tready[0]),
    .s_axis_tlast(s_tlast[0]), .m_axis_tdata(m_tdata[0]), .m_axis_tvalid(m_tvalid[0]),
    .m_axis_tready(m_tready[0]), .m_axis_tlast(m_tlast[0]), .grant_id(gid[0]),
    .busy(busy[0]), .trunc_pulse(trunc[0])
  );

  manchester_tx_scheduler #(
    .NUM_SRC(NS), .DATA_WIDTH(DW), .HDR_TAG(8'hA0), .MAX_LEN(4), .IFG_CYCLES(0)
  ) dut1 (
    .aclk(aclk), .aresetn(aresetn), .enable(enable),
    .s_axis_tdata(s_tdata[1]), .s_axis_tvalid(s_tvalid[1]), .s_axis_tready(s_tready[1]),
    .s_axis_tlast(s_tlast[1]), .m_axis_tdata(m_tdata[1]), .m_axis_tvalid(m_tvalid[1]),
    .m_axis_tready(m_tready[1]), .m_axis_tlast(m_tlast[1]), .grant_id(gid[1]),
    .busy(busy[1]), .trunc_pulse(trunc[1])
  );

  function automatic int lane_max(input int l);
    return (l == 0) ? 256 : 4;
  endfunction

  task automatic check(input string nm, input int l, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s lane%0d @%0t: got %0h, want %0h", nm, l, $time, act, req);
    end
  endtask

  // Source and sink drivers: pop on handshakes seen before the edge, drive just after it.
  logic [NS-1:0] hs [2];
  initial begin
    for (int l = 0; l < 2; l++) begin
      s_tvalid[l] = '0; s_tlast[l] = '0; s_tdata[l] = '0; m_tready[l] = 1'b1;
    end
    forever begin
      @(negedge aclk);
      for (int l = 0; l < 2; l++) hs[l] = s_tvalid[l] & s_tready[l];
      @(posedge aclk);
      #1;
      for (int l = 0; l < 2; l++) begin
        for (int s = 0; s < NS; s++) begin
          if (hs[l][s] && srcq[l][s].size() > 0) void'(srcq[l][s].pop_front());
          if (srcq[l][s].size() > 0) begin
            s_tvalid[l][s]         = 1'b1;
            s_tdata[l][s*DW +: DW] = srcq[l][s][0].data;
            s_tlast[l][s]          = srcq[l][s][0].last;
          end else begin
            s_tvalid[l][s]         = 1'b0;
            s_tdata[l][s*DW +: DW] = '0;
            s_tlast[l][s]          = 1'b0;
          end
        end
        m_tready[l] = rmode[l] ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  // Compare process: every cycle, both lanes.
  logic       prev_stall [2];
  logic [7:0] prev_data  [2];
  logic       prev_last  [2];
  logic       seen_last  [2];
  logic       hb_on      [2];
  int         idle_cnt   [2];
  int         hb_cnt     [2];
  initial begin
    exp_t e;
    for (int l = 0; l < 2; l++) begin
      prev_stall[l] = 1'b0; seen_last[l] = 1'b0; hb_on[l] = 1'b0;
      idle_cnt[l] = 0; hb_cnt[l] = 0; prev_data[l] = '0; prev_last[l] = 1'b0;
    end
    forever begin
      @(negedge aclk);
      for (int l = 0; l < 2; l++) begin
        if (!aresetn) begin
          prev_stall[l] = 1'b0; seen_last[l] = 1'b0; hb_on[l] = 1'b0;
          continue;
        end
        if (prev_stall[l]) begin
          check("hold_valid", l, 32'(m_tvalid[l]), 1);
          check("hold_data",  l, 32'(m_tdata[l]),  32'(prev_data[l]));
          check("hold_last",  l, 32'(m_tlast[l]),  32'(prev_last[l]));
        end
        if (busy[l]) check("ready_excl", l, 32'(s_tready[l] & ~(4'b0001 << gid[l])), 0);
        else         check("ready_idle", l, 32'(s_tready[l]), 0);
        if (m_tvalid[l]) check("busy_while_valid", l, 32'(busy[l]), 1);
        if (trunc[l]) trunc_cnt[l]++;
        if (m_tvalid[l] && m_tready[l]) begin
          check("beat_expected", l, 32'(expq[l].size() > 0), 1);
          if (expq[l].size() > 0) begin
            e = expq[l].pop_front();
            check("beat_data", l, 32'(m_tdata[l]), 32'(e.data));
            check("beat_last", l, 32'(m_tlast[l]), 32'(e.last));
            if (e.hdr) begin
              check("hdr_grant_id", l, 32'(gid[l]), 32'(e.src));
              if (seen_last[l]) last_gap[l] = idle_cnt[l];
              seen_last[l] = 1'b0;
              hb_on[l] = 1'b1;
              hb_cnt[l] = 0;
            end else if (hb_on[l]) begin
              last_bubble[l] = hb_cnt[l];
              hb_on[l] = 1'b0;
            end
            if (e.last) begin
              seen_last[l] = 1'b1;
              idle_cnt[l] = 0;
            end
            outlog[l].push_back({m_tdata[l], m_tlast[l], e.hdr, e.src});
          end
        end else if (!m_tvalid[l]) begin
          idle_cnt[l]++;
          if (hb_on[l]) hb_cnt[l]++;
        end
        prev_stall[l] = m_tvalid[l] && !m_tready[l];
        prev_data[l]  = m_tdata[l];
        prev_last[l]  = m_tlast[l];
      end
    end
  end

  task automatic tick();
    @(negedge aclk);
    #2;
  endtask

  // Queue a packet on a source and the beats the scheduler must emit for it.
  task automatic send(input int l, input int src, input int n, input logic [7:0] first, input logic [7:0] step);
    logic [7:0] b;
    int lim;
    lim = (n < lane_max(l)) ? n : lane_max(l);
    expq[l].push_back({8'hA0 | 8'(src), 1'b0, 1'b1, 2'(src)});
    for (int i = 0; i < n; i++) begin
      b = first + 8'(i) * step;
      srcq[l][src].push_back({b, (i == n - 1)});
      if (i < lim) expq[l].push_back({b, (i == n - 1) || (i == lane_max(l) - 1), 1'b0, 2'(src)});
    end
  endtask

  function automatic bit src_pending(input int l);
    for (int s = 0; s < NS; s++) if (srcq[l][s].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_done(input int l, input int budget);
    int k;
    k = 0;
    while ((expq[l].size() != 0 || src_pending(l) || busy[l]) && k < budget) begin
      tick();
      k++;
    end
    check("pending_beats", l, 32'(expq[l].size()), 0);
    check("busy_end", l, 32'(busy[l]), 0);
  endtask

  task automatic wait_log(input int l, input int n, input int budget);
    int k;
    k = 0;
    while (outlog[l].size() < n && k < budget) begin
      tick();
      k++;
    end
    check("log_reached", l, 32'(outlog[l].size() >= n), 1);
  endtask

  task automatic do_reset();
    @(posedge aclk);
    #1 aresetn = 1'b0;
    tick();
    for (int l = 0; l < 2; l++) begin
      for (int s = 0; s < NS; s++) srcq[l][s].delete();
      expq[l].delete();
      outlog[l].delete();
    end
    tick();
    for (int l = 0; l < 2; l++) begin
      check("rst_tvalid", l, 32'(m_tvalid[l]), 0);
      check("rst_tlast",  l, 32'(m_tlast[l]),  0);
      check("rst_tdata",  l, 32'(m_tdata[l]),  0);
      check("rst_tready", l, 32'(s_tready[l]), 0);
      check("rst_busy",   l, 32'(busy[l]),     0);
      check("rst_trunc",  l, 32'(trunc[l]),    0);
      check("rst_grant",  l, 32'(gid[l]),      3);
      trunc_cnt[l] = 0; last_gap[l] = -1; last_bubble[l] = -1;
    end
    aresetn = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn = 1'b1;
    enable  = 1'b1;
    rmode[0] = 1'b0;
    rmode[1] = 1'b0;
    do_reset();

    // Single packet from src0, always-ready sink.
    send(0, 0, 3, 8'h11, 8'h11);
    repeat (3) tick();
    check("t1_busy", 0, 32'(busy[0]), 1);
    wait_done(0, 200);
    check("t1_len",   0, 32'(outlog[0].size()), 4);
    check("t1_hdr",   0, 32'(outlog[0][0].data), 32'hA0);
    check("t1_b1",    0, 32'(outlog[0][1].data), 32'h11);
    check("t1_b2",    0, 32'(outlog[0][2].data), 32'h22);
    check("t1_b3",    0, 32'(outlog[0][3].data), 32'h33);
    check("t1_last2", 0, 32'(outlog[0][2].last), 0);
    check("t1_last3", 0, 32'(outlog[0][3].last), 1);
    check("t1_bubble", 0, 32'(last_bubble[0]), 1);

    // Two sources contending: strict alternation.
    do_reset();
    send(0, 0, 2, 8'h01, 8'h01);
    send(0, 2, 2, 8'h21, 8'h01);
    send(0, 0, 2, 8'h03, 8'h01);
    send(0, 2, 2, 8'h23, 8'h01);
    wait_done(0, 300);
    check("t2_len",  0, 32'(outlog[0].size()), 12);
    check("t2_hdr0", 0, 32'(outlog[0][0].data), 32'hA0);
    check("t2_hdr1", 0, 32'(outlog[0][3].data), 32'hA2);
    check("t2_hdr2", 0, 32'(outlog[0][6].data), 32'hA0);
    check("t2_hdr3", 0, 32'(outlog[0][9].data), 32'hA2);

    // Random backpressure on an 8-beat packet.
    do_reset();
    rmode[0] = 1'b1;
    send(0, 0, 8, 8'h81, 8'h01);
    wait_done(0, 400);
    rmode[0] = 1'b0;
    check("t3_len",  0, 32'(outlog[0].size()), 9);
    check("t3_tail", 0, 32'(outlog[0][8].data), 32'h88);

    // Truncation at MAX_LEN=4, then a normal packet.
    do_reset();
    send(1, 1, 6, 8'h01, 8'h01);
    send(1, 1, 2, 8'h07, 8'h01);
    wait_done(1, 300);
    check("t4_len",     1, 32'(outlog[1].size()), 8);
    check("t4_cut",     1, 32'(outlog[1][4].data), 32'h04);
    check("t4_cutlast", 1, 32'(outlog[1][4].last), 1);
    check("t4_hdr2",    1, 32'(outlog[1][5].data), 32'hA1);
    check("t4_tail",    1, 32'(outlog[1][7].data), 32'h08);
    check("t4_trunc",   1, 32'(trunc_cnt[1]), 1);
    check("t4_drained", 1, 32'(srcq[1][1].size()), 0);

    // Inter-frame gap: IFG 4 on lane 0, IFG 0 on lane 1.
    do_reset();
    send(0, 3, 2, 8'h51, 8'h01);
    send(0, 3, 2, 8'h53, 8'h01);
    wait_done(0, 300);
    check("t5_gap_ge4", 0, 32'(last_gap[0] >= 4), 1);
    do_reset();
    send(1, 3, 2, 8'h61, 8'h01);
    send(1, 3, 2, 8'h63, 8'h01);
    wait_done(1, 300);
    check("t5_gap0", 1, 32'(last_gap[1]), 1);

    // Reset mid-packet, then src0 wins over src1; then src1 alone.
    do_reset();
    send(0, 1, 6, 8'h31, 8'h01);
    wait_log(0, 3, 100);
    do_reset();
    send(0, 0, 1, 8'h71, 8'h01);
    send(0, 1, 2, 8'h41, 8'h01);
    wait_done(0, 300);
    check("t6_hdr0", 0, 32'(outlog[0][0].data), 32'hA0);
    check("t6_hdr1", 0, 32'(outlog[0][2].data), 32'hA1);
    do_reset();
    send(0, 1, 1, 8'h72, 8'h01);
    wait_done(0, 200);
    check("t6_only1", 0, 32'(outlog[0][0].data), 32'hA1);

    // Enable low blocks the grant; grant_id holds afterwards in IDLE.
    do_reset();
    enable = 1'b0;
    send(1, 2, 1, 8'h99, 8'h01);
    repeat (10) tick();
    check("t7_blocked_busy", 1, 32'(busy[1]), 0);
    check("t7_blocked_out",  1, 32'(outlog[1].size()), 0);
    enable = 1'b1;
    wait_done(1, 200);
    check("t7_hdr",   1, 32'(outlog[1][0].data), 32'hA2);
    check("t7_grant", 1, 32'(gid[1]), 2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
